// File: rtl/player_multi_if.sv
// Handshake bundle between the player block and its pulse sources / consumers.
// master drives the debounced pulses; slave (the player) drives ship, bullet and game status.
interface player_multi_if #(
  parameter int unsigned X_WIDTH     = 5,
  parameter int unsigned Y_WIDTH     = 4,
  parameter int unsigned NUM_BULLETS = 2,
  parameter int unsigned SCORE_WIDTH = 8
);
  logic                           enable;
  logic                           left;
  logic                           right;
  logic                           shoot;
  logic                           start;
  logic                           clear_score;
  logic [NUM_BULLETS-1:0]         hit;
  logic                           player_hit;
  logic [X_WIDTH-1:0]             ship_x;
  logic [NUM_BULLETS*X_WIDTH-1:0] bullet_x;
  logic [NUM_BULLETS*Y_WIDTH-1:0] bullet_y;
  logic [NUM_BULLETS-1:0]         bullet_flying;
  logic [SCORE_WIDTH-1:0]         score;
  logic [2:0]                     lives;
  logic [1:0]                     state;

  modport master (
    output enable, left, right, shoot, start, clear_score, hit, player_hit,
    input  ship_x, bullet_x, bullet_y, bullet_flying, score, lives, state
  );

  modport slave (
    input  enable, left, right, shoot, start, clear_score, hit, player_hit,
    output ship_x, bullet_x, bullet_y, bullet_flying, score, lives, state
  );
endinterface

// File: rtl/player_multi.sv
// Player ship, multi-slot bullet pool with cooldown, saturating score, lives and game FSM.
// Hits act every cycle; movement, bullets and the death timer advance on enable ticks.
module player_multi #(
  parameter int unsigned X_WIDTH     = 5,
  parameter int unsigned Y_WIDTH     = 4,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = 31,
  parameter int unsigned Y_START     = 14,
  parameter int unsigned NUM_BULLETS = 2,
  parameter int unsigned SCORE_WIDTH = 8,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned COOLDOWN    = 4,
  parameter int unsigned DEATH_TICKS = 8
) (
  input logic           clk_36MHz,
  input logic           reset,
  player_multi_if.slave bus
);
  localparam int unsigned CENTER = (X_MIN + X_MAX) / 2;
  localparam int unsigned CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int unsigned DT_W   = $clog2(DEATH_TICKS + 1);
  localparam int unsigned CNT_W  = $clog2(NUM_BULLETS + 1);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPlaying  = 2'd1,
    StDying    = 2'd2,
    StGameOver = 2'd3
  } state_e;

  state_e                              state_q;
  logic [X_WIDTH-1:0]                  ship_x_q;
  logic [NUM_BULLETS-1:0][X_WIDTH-1:0] bullet_x_q;
  logic [NUM_BULLETS-1:0][Y_WIDTH-1:0] bullet_y_q;
  logic [NUM_BULLETS-1:0]              flying_q;
  logic [SCORE_WIDTH-1:0]              score_q;
  logic [2:0]                          lives_q;
  logic [CD_W-1:0]                     cooldown_q;
  logic [DT_W-1:0]                     death_q;
  logic                                pend_l_q;
  logic                                pend_r_q;
  logic                                pend_s_q;

  logic                         go_left;
  logic                         go_right;
  logic                         go_shoot;
  logic                         found;
  logic [NUM_BULLETS-1:0]       valid_hit;
  logic [NUM_BULLETS-1:0]       free_after;
  logic [NUM_BULLETS-1:0]       launch_sel;
  logic [CNT_W-1:0]             hit_cnt;
  logic [SCORE_WIDTH+CNT_W-1:0] score_sum;
  logic [SCORE_WIDTH-1:0]       score_sat;

  // A pulse coincident with the tick counts for that tick.
  always_comb begin
    go_left    = pend_l_q | bus.left;
    go_right   = pend_r_q | bus.right;
    go_shoot   = pend_s_q | bus.shoot;
    valid_hit  = bus.hit & flying_q;
    hit_cnt    = '0;
    free_after = '0;
    launch_sel = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      hit_cnt = hit_cnt + CNT_W'(valid_hit[i]);
      // Slots freed by a hit this cycle are not reusable until the next cycle.
      free_after[i] = !valid_hit[i] && (!flying_q[i] || bullet_y_q[i] == '0);
      if (free_after[i] && !found && go_shoot && cooldown_q == '0) begin
        launch_sel[i] = 1'b1;
        found         = 1'b1;
      end
    end
    score_sum = {{CNT_W{1'b0}}, score_q} + {{SCORE_WIDTH{1'b0}}, hit_cnt};
    score_sat = (|score_sum[SCORE_WIDTH +: CNT_W]) ? '1 : score_sum[SCORE_WIDTH-1:0];
  end

  always_ff @(posedge clk_36MHz) begin
    if (!reset) begin
      state_q    <= StIdle;
      ship_x_q   <= X_WIDTH'(CENTER);
      bullet_x_q <= '0;
      bullet_y_q <= '0;
      flying_q   <= '0;
      score_q    <= '0;
      lives_q    <= 3'(LIVES);
      cooldown_q <= '0;
      death_q    <= '0;
      pend_l_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      pend_s_q   <= 1'b0;
    end else begin
      if (bus.clear_score) begin
        score_q <= '0;
      end
      unique case (state_q)
        StIdle: begin
          ship_x_q <= X_WIDTH'(CENTER);
          flying_q <= '0;
          pend_l_q <= 1'b0;
          pend_r_q <= 1'b0;
          pend_s_q <= 1'b0;
          if (bus.start) begin
            state_q    <= StPlaying;
            lives_q    <= 3'(LIVES);
            score_q    <= '0;
            cooldown_q <= '0;
          end
        end

        StPlaying: begin
          if (bus.player_hit) begin
            flying_q   <= '0;
            cooldown_q <= '0;
            lives_q    <= lives_q - 3'd1;
            pend_l_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            pend_s_q   <= 1'b0;
            if (lives_q == 3'd1) begin
              state_q <= StGameOver;
            end else begin
              state_q <= StDying;
              death_q <= DT_W'(DEATH_TICKS);
            end
          end else begin
            if (!bus.clear_score) begin
              score_q <= score_sat;
            end
            if (bus.enable) begin
              pend_l_q <= 1'b0;
              pend_r_q <= 1'b0;
              pend_s_q <= 1'b0;
              if (go_left && !go_right && ship_x_q != X_WIDTH'(X_MIN)) begin
                ship_x_q <= ship_x_q - X_WIDTH'(1);
              end else if (go_right && !go_left && ship_x_q != X_WIDTH'(X_MAX)) begin
                ship_x_q <= ship_x_q + X_WIDTH'(1);
              end
              if (|launch_sel) begin
                cooldown_q <= CD_W'(COOLDOWN);
              end else if (cooldown_q != '0) begin
                cooldown_q <= cooldown_q - CD_W'(1);
              end
            end else begin
              pend_l_q <= pend_l_q | bus.left;
              pend_r_q <= pend_r_q | bus.right;
              pend_s_q <= pend_s_q | bus.shoot;
            end
            for (int i = 0; i < NUM_BULLETS; i++) begin
              if (bus.enable) begin
                if (launch_sel[i]) begin
                  bullet_x_q[i] <= ship_x_q;
                  bullet_y_q[i] <= Y_WIDTH'(Y_START);
                  flying_q[i]   <= 1'b1;
                end else if (flying_q[i]) begin
                  if (bullet_y_q[i] == '0) begin
                    flying_q[i] <= 1'b0;
                  end else begin
                    bullet_y_q[i] <= bullet_y_q[i] - Y_WIDTH'(1);
                  end
                end
              end
              // A hit wins over this cycle's tick update of the same slot.
              if (valid_hit[i]) begin
                flying_q[i] <= 1'b0;
              end
            end
          end
        end

        StDying: begin
          pend_l_q <= 1'b0;
          pend_r_q <= 1'b0;
          pend_s_q <= 1'b0;
          if (bus.enable) begin
            death_q <= death_q - DT_W'(1);
            if (death_q == DT_W'(1)) begin
              state_q  <= StPlaying;
              ship_x_q <= X_WIDTH'(CENTER);
            end
          end
        end

        StGameOver: begin
          pend_l_q <= 1'b0;
          pend_r_q <= 1'b0;
          pend_s_q <= 1'b0;
          if (bus.start) begin
            state_q    <= StPlaying;
            lives_q    <= 3'(LIVES);
            score_q    <= '0;
            cooldown_q <= '0;
            ship_x_q   <= X_WIDTH'(CENTER);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.state         = state_q;
  assign bus.ship_x        = ship_x_q;
  assign bus.bullet_x      = bullet_x_q;
  assign bus.bullet_y      = bullet_y_q;
  assign bus.bullet_flying = flying_q;
  assign bus.score         = score_q;
  assign bus.lives         = lives_q;
endmodule

// File: tb/tb_player_multi.sv
// Bench for player_multi: directed scenarios plus random pulses, checked every cycle
// against an integer-level game model.
module tb_player_multi;
  localparam int XW = 5, YW = 4, NB = 2, SW = 8;
  localparam int XMIN = 0, XMAX = 31, YST = 14, COOL = 4, DEATH = 8, NLIVES = 3;
  localparam int CENTER = (XMIN + XMAX) / 2;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  player_multi_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .NUM_BULLETS(NB), .SCORE_WIDTH(SW)) bus ();

  player_multi #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .X_MIN(XMIN), .X_MAX(XMAX), .Y_START(YST),
    .NUM_BULLETS(NB), .SCORE_WIDTH(SW), .LIVES(NLIVES), .COOLDOWN(COOL), .DEATH_TICKS(DEATH)
  ) dut (
    .clk_36MHz(clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Game model: 0 idle, 1 playing, 2 dying, 3 game over.
  int m_state, m_ship, m_lives, m_score, m_cd, m_death;
  bit m_pl, m_pr, m_ps, m_valid;
  bit m_fly[NB];
  int m_bx[NB], m_by[NB];

  function automatic void start_game();
    m_state = 1; m_lives = NLIVES; m_score = 0; m_cd = 0; m_ship = CENTER;
  endfunction

  function automatic void model_step();
    bit l, r, s;
    bit hv[NB];
    int cnt, cd_pre, old_ship;
    if (!rst_n) begin
      m_state = 0; m_ship = CENTER; m_lives = NLIVES; m_score = 0; m_cd = 0; m_death = 0;
      m_pl = 0; m_pr = 0; m_ps = 0; m_valid = 1;
      for (int i = 0; i < NB; i++) begin m_fly[i] = 0; m_bx[i] = 0; m_by[i] = 0; end
      return;
    end
    if (bus.clear_score) m_score = 0;
    case (m_state)
      0: begin
        m_ship = CENTER; m_pl = 0; m_pr = 0; m_ps = 0;
        for (int i = 0; i < NB; i++) m_fly[i] = 0;
        if (bus.start) start_game();
      end
      1: begin
        if (bus.player_hit) begin
          for (int i = 0; i < NB; i++) m_fly[i] = 0;
          m_cd = 0; m_lives--; m_pl = 0; m_pr = 0; m_ps = 0;
          if (m_lives == 0) m_state = 3;
          else begin m_state = 2; m_death = DEATH; end
        end else begin
          cnt = 0;
          for (int i = 0; i < NB; i++) begin hv[i] = bus.hit[i] && m_fly[i]; cnt += int'(hv[i]); end
          if (!bus.clear_score) m_score = (m_score + cnt > SMAX) ? SMAX : m_score + cnt;
          l = m_pl | bus.left; r = m_pr | bus.right; s = m_ps | bus.shoot;
          if (bus.enable) begin
            old_ship = m_ship;
            if (l && !r) m_ship = (m_ship > XMIN) ? m_ship - 1 : XMIN;
            if (r && !l) m_ship = (m_ship < XMAX) ? m_ship + 1 : XMAX;
            cd_pre = m_cd;
            if (m_cd > 0) m_cd--;
            for (int i = 0; i < NB; i++)
              if (m_fly[i]) begin
                if (m_by[i] == 0) m_fly[i] = 0; else m_by[i]--;
              end
            for (int i = 0; i < NB; i++) if (hv[i]) m_fly[i] = 0;
            if (s && cd_pre == 0)
              for (int i = 0; i < NB; i++)
                if (!m_fly[i] && !hv[i]) begin
                  m_fly[i] = 1; m_bx[i] = old_ship; m_by[i] = YST; m_cd = COOL;
                  break;
                end
            m_pl = 0; m_pr = 0; m_ps = 0;
          end else begin
            m_pl = l; m_pr = r; m_ps = s;
            for (int i = 0; i < NB; i++) if (hv[i]) m_fly[i] = 0;
          end
        end
      end
      2: begin
        m_pl = 0; m_pr = 0; m_ps = 0;
        if (bus.enable) begin
          m_death--;
          if (m_death == 0) begin m_state = 1; m_ship = CENTER; end
        end
      end
      default: begin
        m_pl = 0; m_pr = 0; m_ps = 0;
        if (bus.start) start_game();
      end
    endcase
  endfunction

  // Single compare process: advance the model at the edge, check the DUT just after it.
  always @(posedge clk) begin
    logic [NB-1:0] fv;
    model_step();
    #1;
    if (m_valid) begin
      for (int i = 0; i < NB; i++) fv[i] = m_fly[i];
      check("state", bus.state, m_state);
      check("ship_x", bus.ship_x, m_ship);
      check("lives", bus.lives, m_lives);
      check("score", bus.score, m_score);
      check("bullet_flying", bus.bullet_flying, fv);
      for (int i = 0; i < NB; i++)
        if (m_fly[i]) begin
          check($sformatf("bullet_x[%0d]", i), bus.bullet_x[i*XW +: XW], m_bx[i]);
          check($sformatf("bullet_y[%0d]", i), bus.bullet_y[i*YW +: YW], m_by[i]);
        end
    end
  end

  task automatic drive(input bit en, l, r, s, st, clr, ph, input logic [NB-1:0] h);
    bus.enable = en; bus.left = l; bus.right = r; bus.shoot = s; bus.start = st;
    bus.clear_score = clr; bus.player_hit = ph; bus.hit = h;
    @(posedge clk); @(negedge clk);
    bus.enable = 0; bus.left = 0; bus.right = 0; bus.shoot = 0; bus.start = 0;
    bus.clear_score = 0; bus.player_hit = 0; bus.hit = '0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic tick(input bit l, r, s);
    drive(1, l, r, s, 0, 0, 0, '0);
    idle();
  endtask

  task automatic do_reset();
    rst_n = 0; idle(); rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.enable = 0; bus.left = 0; bus.right = 0; bus.shoot = 0; bus.start = 0;
    bus.clear_score = 0; bus.player_hit = 0; bus.hit = '0;
    @(negedge clk);
    do_reset(); idle();
    check("rst state", bus.state, 0);
    check("rst ship_x", bus.ship_x, 15);
    check("rst lives", bus.lives, 3);
    check("rst score", bus.score, 0);

    // Movement and clamping.
    drive(0, 0, 0, 0, 1, 0, 0, '0);
    check("start state", bus.state, 1);
    tick(0, 1, 0);
    check("right once", bus.ship_x, 16);
    for (int i = 0; i < 19; i++) begin idle(); drive(0, 0, 1, 0, 0, 0, 0, '0); tick(0, 0, 0); end
    check("right clamp", bus.ship_x, 31);
    drive(0, 1, 0, 0, 0, 0, 0, '0);
    tick(0, 1, 0);
    check("left+right", bus.ship_x, 31);

    // Shots every tick with cooldown 4.
    for (int t = 0; t < 16; t++) begin
      tick(0, 0, 1);
      if (t == 0) begin
        check("t0 flying", bus.bullet_flying, 2'b01);
        check("t0 y0", bus.bullet_y[3:0], 14);
        check("t0 x0", bus.bullet_x[4:0], 31);
      end
      if (t == 4) check("t4 flying", bus.bullet_flying, 2'b01);
      if (t == 5) check("t5 flying", bus.bullet_flying, 2'b11);
      if (t == 14) check("t14 y0", bus.bullet_y[3:0], 0);
      if (t == 15) begin
        check("t15 flying", bus.bullet_flying, 2'b11);
        check("t15 y0", bus.bullet_y[3:0], 14);
        check("t15 y1", bus.bullet_y[7:4], 4);
      end
    end

    // Drive score to 254, then saturate with a double hit.
    guard = 0;
    while (m_score < 254 && guard < 3000) begin
      tick(0, 0, 1);
      if (m_fly[0]) drive(0, 0, 0, 0, 0, 0, 0, 2'b01);
      guard++;
    end
    check("score 254", bus.score, 254);
    guard = 0;
    while (!(m_fly[0] && m_fly[1]) && guard < 40) begin tick(0, 0, 1); guard++; end
    check("both flying", bus.bullet_flying, 2'b11);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b11);
    check("sat score", bus.score, 255);
    check("sat freed", bus.bullet_flying, 2'b00);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b11);
    check("idle hit score", bus.score, 255);

    // Hit coincident with a tick.
    drive(0, 0, 0, 0, 0, 1, 0, '0);
    check("clear score", bus.score, 0);
    guard = 0;
    while (!m_fly[0] && guard < 20) begin tick(0, 0, 1); guard++; end
    drive(1, 0, 0, 0, 0, 0, 0, 2'b01);
    check("tick hit freed", bus.bullet_flying[0], 0);
    check("tick hit score", bus.score, 1);

    // Lives and game over.
    drive(0, 0, 0, 0, 0, 0, 1, '0);
    check("ph1 lives", bus.lives, 2);
    check("ph1 state", bus.state, 2);
    for (int i = 0; i < 7; i++) tick(1, 0, 1);
    check("dying 7", bus.state, 2);
    tick(0, 0, 0);
    check("dying end", bus.state, 1);
    check("recentre", bus.ship_x, 15);
    drive(0, 0, 0, 0, 0, 0, 1, '0);
    check("ph2 lives", bus.lives, 1);
    for (int i = 0; i < 8; i++) tick(0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, '0);
    check("ph3 lives", bus.lives, 0);
    check("game over", bus.state, 3);
    check("score kept", bus.score, 1);
    tick(0, 1, 1);
    check("frozen ship", bus.ship_x, 15);
    drive(0, 0, 0, 0, 1, 0, 0, '0);
    check("restart state", bus.state, 1);
    check("restart lives", bus.lives, 3);
    check("restart score", bus.score, 0);

    // Random pulses.
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 149) == 0, NB'($urandom_range(0, 3) & $urandom_range(0, 3)));
      rst_n = 1;
    end

    // Reset mid-flight.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0, '0);
    tick(0, 0, 1);
    for (int i = 0; i < 7; i++) tick(0, 0, 0);
    check("mid y0", bus.bullet_y[3:0], 7);
    do_reset();
    check("mr state", bus.state, 0);
    check("mr flying", bus.bullet_flying, 0);
    check("mr bx", bus.bullet_x, 0);
    check("mr by", bus.bullet_y, 0);
    check("mr score", bus.score, 0);
    check("mr ship", bus.ship_x, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/player_multi.md
# player_multi

Parametrised successor to the single-bullet player block. It tracks the ship position, a pool of NUM_BULLETS independent bullets with a shot cooldown, a saturating score, a lives counter and a game-state FSM (IDLE / PLAYING / DYING / GAME_OVER). Inputs are already-debounced single-cycle pulses from upstream edge_detector_debouncer instances. Outputs feed the renderer and the alien/collision logic.

## Interface
- X_WIDTH, 5: ship/bullet x width
- Y_WIDTH, 4: bullet y width
- X_MIN, 0: leftmost ship column
- X_MAX, 31: rightmost ship column
- Y_START, 14: bullet y at launch
- NUM_BULLETS, 2: bullet slots (≥1)
- SCORE_WIDTH, 8: score width
- LIVES, 3: lives per game (1..7)
- COOLDOWN, 4: enable ticks between launches
- DEATH_TICKS, 8: enable ticks spent in DYING (≥1)

Ports:
- clk_36MHz  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low
- enable  in  1  game tick pulse, one cycle wide
- left, right, shoot, start  in  1 each  debounced single-cycle pulses
- clear_score  in  1  clears score, any state
- hit  in  NUM_BULLETS  hit[i]: bullet slot i struck an alien
- player_hit  in  1  ship struck by alien fire
- ship_x  out  X_WIDTH  ship column
- bullet_x  out  NUM_BULLETS*X_WIDTH  slot i at [i*X_WIDTH +: X_WIDTH]
- bullet_y  out  NUM_BULLETS*Y_WIDTH  slot i at [i*Y_WIDTH +: Y_WIDTH]
- bullet_flying  out  NUM_BULLETS  slot active flags
- score  out  SCORE_WIDTH  hit count, saturating
- lives  out  3  remaining lives
- state  out  2  IDLE=0, PLAYING=1, DYING=2, GAME_OVER=3

## Operation
- CENTER = (X_MIN+X_MAX)/2, integer division.
- Reset values (reset==0 at an edge):
  - state=IDLE, ship_x=CENTER, lives=LIVES.
  - All bullet_flying/bullet_x/bullet_y=0, score=0.
  - Cooldown=0, death counter=0, pending flags cleared.
- Pending flags pend_l, pend_r, pend_s:
  - In PLAYING, a pulse on left/right/shoot sets its flag.
  - An enable tick consumes all flags and clears them.
  - A pulse coincident with enable counts for that tick. Flags are cleared in every other state.
- IDLE:
  - Ship is held at CENTER and bullets are inactive.
  - start → PLAYING; lives=LIVES, score=0, cooldown=0.
- PLAYING, on each enable tick, in this order:
  - Move: pend_l and not pend_r → ship_x−1, clamped at X_MIN. pend_r and not pend_l → +1, clamped at X_MAX. Both set → no move.
  - Flying bullets: y==0 → slot freed; otherwise y−1.
  - Cooldown >0 → decrement.
  - Launch: pend_s and cooldown==0 (pre-decrement value) and a slot is free after this tick's frees. The lowest-index free slot gets x = pre-move ship_x, y = Y_START, flying=1, and cooldown=COOLDOWN. No free slot → shot dropped, no queueing.
- Hits, every cycle regardless of enable:
  - A valid hit is hit[i] && bullet_flying[i]; that slot is freed at the next edge.
  - A hit overrides any same-cycle tick update of that slot.
  - A freed slot is not reusable in the same cycle.
  - hit[i] on an inactive slot is ignored.
- Score:
  - Each cycle, score += popcount(valid hits), saturating at 2^SCORE_WIDTH−1.
  - clear_score has priority over the increment.
  - Score is held in GAME_OVER and DYING. Hits are accepted only in PLAYING.
- player_hit in PLAYING (priority over all same-cycle tick and hit effects):
  - All bullets freed, cooldown=0, lives−1.
  - If the new lives==0 → GAME_OVER. Otherwise → DYING with death counter=DEATH_TICKS.
- DYING:
  - The death counter decrements each enable tick.
  - On reaching 0 → PLAYING with ship_x=CENTER.
  - Movement, shoot, hit and player_hit are ignored.
- GAME_OVER:
  - Everything is frozen except clear_score.
  - start → PLAYING with the same effects as the start from IDLE.
- start in PLAYING or DYING is ignored.

## Timing
- All outputs are registered. Effects appear one cycle after the causing edge.
- Tick latency: a move/shot pulse arriving k cycles before enable is applied at the enable edge and visible on the next cycle.
- Hit to score/free latency is 1 cycle.
- player_hit to state/lives latency is 1 cycle.
- Bullet lifetime from launch is Y_START+1 ticks (visible at Y_START..0), then freed on the next tick.
- With COOLDOWN=c, the minimum spacing between launches is c+1 ticks.
- Reset mid-game returns all state to the reset values on the next cycle.

## Test plan
- Reset, start, then 20 ticks each preceded by a right pulse → ship_x 16→31 and holds at 31. Left+right pulses in the same tick → no move.
- shoot every tick, COOLDOWN=4, NUM_BULLETS=2 → launches at ticks 0 and 5. Slot 0 then slot 1. The third shot succeeds only after slot 0 frees at tick 15.
- hit=2'b11 with both slots flying, score=254, SCORE_WIDTH=8 → score=255 (saturated), both slots freed next cycle. hit on an inactive slot → no change.
- hit on a flying slot coincident with enable → slot freed, not decremented; score+1.
- player_hit ×3 with ticks between → lives 2 (DYING, 8 ticks, ship recentred), then 1, then 0 and GAME_OVER. Score is retained; start → PLAYING, lives=3, score=0.
- Reset asserted mid-flight with a bullet at y=7 → next cycle state=IDLE, bullets clear, score=0, ship_x=15.
